weight_mem_arbiter: RTL and testbench

- Shares the single external read port among three requesters: RDN weight load (index 0), DNN weight load (index 1) and IPGU image fetch (index 2).
- Each requester asks for a burst of 512-bit lines from a base address.
- The arbiter grants one requester at a time, round-robin, and issues one line read at a time to memory.
- Returned lines go to the granted requester over a shared data bus with a per-requester valid strobe.

---
 rtl/pipeline_mem_pkg.sv | 27 ++
 rtl/weight_mem_arbiter_if.sv | 35 +++
 rtl/rr_arbiter3.sv | 24 ++
 rtl/weight_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_weight_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_mem_pkg.sv
// Shared definitions for the weight/image memory read path: requester indices,
// line geometry and the arbiter state encoding.
package pipeline_mem_pkg;

   localparam int NUM_REQ  = 3;
   localparam int REQ_RDN  = 0;
   localparam int REQ_DNN  = 1;
   localparam int REQ_IPGU = 2;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LINE_W = 512;
   localparam int DEF_LEN_W  = 8;
   localparam int LINE_BYTES = DEF_LINE_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   // Round-robin pointer moves to the requester after the winner, cyclically.
   function automatic logic [1:0] next_ptr(input logic [1:0] idx);
      return (idx >= 2'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/weight_mem_arbiter_if.sv
// Requester-side and memory-side signals of the shared weight read port.
// Handshake: a line read is accepted in a cycle where mem_req && mem_ready;
// mem_req and mem_addr stay stable until that cycle; mem_rd_vld qualifies mem_rd_data.
interface weight_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 512,
   parameter int LEN_W  = 8
);
   import pipeline_mem_pkg::*;

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][LEN_W-1:0]  req_len;
   logic [NUM_REQ-1:0]             gnt;
   logic [NUM_REQ-1:0]             rd_vld;
   logic [LINE_W-1:0]              rd_data;
   logic [NUM_REQ-1:0]             done;
   logic                           mem_req;
   logic [ADDR_W-1:0]              mem_addr;
   logic                           mem_ready;
   logic                           mem_rd_vld;
   logic [LINE_W-1:0]              mem_rd_data;
   logic                           err;

   modport master (
      input  req, req_addr, req_len, mem_ready, mem_rd_vld, mem_rd_data,
      output gnt, rd_vld, rd_data, done, mem_req, mem_addr, err
   );

   modport slave (
      output req, req_addr, req_len, mem_ready, mem_rd_vld, mem_rd_data,
      input  gnt, rd_vld, rd_data, done, mem_req, mem_addr, err
   );

endinterface

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin picker: first set request at or after
// the pointer, searching cyclically.
module rr_arbiter3
   import pipeline_mem_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] pick,
   output logic       valid
);

   always_comb begin
      pick  = '0;
      valid = |req;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(ptr) + k) % NUM_REQ;
         if (req[idx] && (pick == '0)) begin
            pick[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/weight_mem_arbiter.sv
// Round-robin owner of the external line read port: grants one requester a
// whole burst and walks it one 512-bit line at a time.
module weight_mem_arbiter
   import pipeline_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LINE_W = DEF_LINE_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   weight_mem_arbiter_if.master bus,
   output arb_state_e           dbg_state
);

   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(LINE_W / 8);

   arb_state_e          state_q, state_d;
   logic [1:0]          ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [NUM_REQ-1:0]  rd_vld_q, rd_vld_d;
   logic [LINE_W-1:0]   rd_data_q, rd_data_d;
   logic                err_q, err_d;

   logic [NUM_REQ-1:0]  pick;
   logic                pick_vld;
   logic [ADDR_W-1:0]   win_addr;
   logic [LEN_W-1:0]    win_len;
   logic [1:0]          win_idx;

   rr_arbiter3 u_rr (
      .req   (bus.req),
      .ptr   (ptr_q),
      .pick  (pick),
      .valid (pick_vld)
   );

   always_comb begin
      win_addr = '0;
      win_len  = '0;
      win_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick[k]) begin
            win_addr = bus.req_addr[k];
            win_len  = bus.req_len[k];
            win_idx  = 2'(k);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      addr_d    = addr_q;
      len_d     = len_q;
      rd_vld_d  = '0;
      rd_data_d = rd_data_q;
      err_d     = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               gnt_d   = pick;
               addr_d  = win_addr;
               len_d   = win_len;
               ptr_d   = next_ptr(win_idx);
               state_d = (win_len == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.mem_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.mem_rd_vld) begin
               rd_vld_d  = gnt_q;
               rd_data_d = bus.mem_rd_data;
               addr_d    = addr_q + ADDR_STEP;
               len_d     = len_q - LEN_W'(1);
               state_d   = (len_q == LEN_W'(1)) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_DONE: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Read data outside WAIT has no owner: drop it and flag the protocol breach.
      if (bus.mem_rd_vld && (state_q != ST_WAIT)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         gnt_q     <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         rd_vld_q  <= '0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         rd_vld_q  <= rd_vld_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.rd_vld   = rd_vld_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.done     = (state_q == ST_DONE) ? gnt_q : '0;
   assign bus.mem_req  = (state_q == ST_ISSUE);
   assign bus.mem_addr = addr_q;
   assign bus.err      = err_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// Directed bench for weight_mem_arbiter: a cycle-stepped memory responder,
// an event monitor feeding logs, and a scoreboard of expected returned lines.
module tb_weight_mem_arbiter;
   import pipeline_mem_pkg::*;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 512;
   localparam int LEN_W  = 8;

   typedef logic [LINE_W-1:0] chk_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   weight_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LEN_W(LEN_W)) bus ();
   arb_state_e dbg_state;

   weight_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard / logs ----------------
   int n_checks = 0;
   int n_pass   = 0;

   logic [LINE_W-1:0]  exp_q[$];
   logic [2:0]         exp_vld_q[$];
   logic [2:0]         gnt_log[$];
   logic [2:0]         done_log[$];
   int                 gnt_cyc[$];
   int                 done_cyc[$];
   logic [ADDR_W-1:0]  acc_log[$];
   int                 rd_cnt, mem_req_cnt, stall_hold, cyc;
   logic [2:0]         prev_gnt;
   bit                 drop_on_gnt;

   int                 lat, pend, stall_cnt;
   logic [ADDR_W-1:0]  pend_addr, stall_addr;

   task automatic check(input string tag, input chk_t obs, input chk_t exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic monitor();
      cyc++;
      if (bus.rd_vld != '0) begin
         rd_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_rd_vld", chk_t'(bus.rd_vld), chk_t'(0));
         end else begin
            check("rd_vld", chk_t'(bus.rd_vld), chk_t'(exp_vld_q.pop_front()));
            check("rd_data", bus.rd_data, exp_q.pop_front());
         end
      end
      if (bus.done != '0) begin
         done_log.push_back(bus.done);
         done_cyc.push_back(cyc);
      end
      if ((bus.gnt != '0) && (prev_gnt == '0)) begin
         gnt_log.push_back(bus.gnt);
         gnt_cyc.push_back(cyc);
      end
      prev_gnt = bus.gnt;
      if (bus.mem_req) mem_req_cnt++;
      if (drop_on_gnt && (bus.gnt != '0)) bus.req = '0;
   endtask

   task automatic respond();
      bus.mem_rd_vld = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            bus.mem_rd_vld  = 1'b1;
            bus.mem_rd_data = {16{pend_addr}};
         end
      end
      if (bus.mem_req && (stall_cnt > 0)) begin
         bus.mem_ready = 1'b0;
         stall_cnt--;
         if (bus.mem_addr == stall_addr) stall_hold++;
      end else begin
         bus.mem_ready = 1'b1;
         if (bus.mem_req) begin
            pend      = lat;
            pend_addr = bus.mem_addr;
            acc_log.push_back(bus.mem_addr);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         monitor();
         respond();
      end
   endtask

   task automatic clear_logs();
      exp_q.delete();
      exp_vld_q.delete();
      gnt_log.delete();
      done_log.delete();
      gnt_cyc.delete();
      done_cyc.delete();
      acc_log.delete();
      rd_cnt      = 0;
      mem_req_cnt = 0;
      stall_hold  = 0;
      stall_cnt   = 0;
      prev_gnt    = bus.gnt;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      bus.req = '0;
      pend    = 0;
      step(2);
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic run_until(input int n_done, input int budget, input string tag);
      int k;
      k = 0;
      while ((done_log.size() < n_done) && (k < budget)) begin
         step(1);
         k++;
      end
      check({tag, "_done_count"}, chk_t'(done_log.size()), chk_t'(n_done));
   endtask

   task automatic expect_line(input logic [ADDR_W-1:0] a, input logic [2:0] who);
      exp_q.push_back({16{a}});
      exp_vld_q.push_back(who);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int c0, k;
      rst_n           = 1'b0;
      bus.req         = '0;
      bus.req_addr    = '0;
      bus.req_len     = '0;
      bus.mem_ready   = 1'b1;
      bus.mem_rd_vld  = 1'b0;
      bus.mem_rd_data = '0;
      drop_on_gnt     = 1'b0;
      lat = 2; pend = 0; stall_cnt = 0; stall_addr = '0; pend_addr = '0; cyc = 0;

      // reset values
      do_reset();
      check("rst_gnt",      chk_t'(bus.gnt),      chk_t'(0));
      check("rst_rd_vld",   chk_t'(bus.rd_vld),   chk_t'(0));
      check("rst_done",     chk_t'(bus.done),     chk_t'(0));
      check("rst_mem_req",  chk_t'(bus.mem_req),  chk_t'(0));
      check("rst_err",      chk_t'(bus.err),      chk_t'(0));
      check("rst_mem_addr", chk_t'(bus.mem_addr), chk_t'(0));
      check("rst_rd_data",  bus.rd_data,          chk_t'(0));
      check("rst_state",    chk_t'(dbg_state),    chk_t'(ST_IDLE));

      // single request, two lines
      lat = 2;
      bus.req_addr[0] = 32'h0000_1000;
      bus.req_len[0]  = 8'd2;
      expect_line(32'h0000_1000, 3'b001);
      expect_line(32'h0000_1040, 3'b001);
      drop_on_gnt = 1'b1;
      bus.req = 3'b001;
      run_until(1, 60, "t1");
      step(2);
      check("t1_gnt",      chk_t'(gnt_log[0]),     chk_t'(3'b001));
      check("t1_addr0",    chk_t'(acc_log[0]),     chk_t'(32'h0000_1000));
      check("t1_addr1",    chk_t'(acc_log[1]),     chk_t'(32'h0000_1040));
      check("t1_accepts",  chk_t'(acc_log.size()), chk_t'(2));
      check("t1_rd_count", chk_t'(rd_cnt),         chk_t'(2));
      check("t1_done",     chk_t'(done_log[0]),    chk_t'(3'b001));
      check("t1_err",      chk_t'(bus.err),        chk_t'(0));

      // contention, pointer 0 after reset
      do_reset();
      lat = 1;
      drop_on_gnt = 1'b0;
      bus.req_addr[0] = 32'h0000_0100; bus.req_len[0] = 8'd1;
      bus.req_addr[1] = 32'h0000_0200; bus.req_len[1] = 8'd1;
      bus.req_addr[2] = 32'h0000_0300; bus.req_len[2] = 8'd1;
      expect_line(32'h0000_0100, 3'b001);
      expect_line(32'h0000_0200, 3'b010);
      expect_line(32'h0000_0300, 3'b100);
      expect_line(32'h0000_0100, 3'b001);
      c0 = cyc;
      bus.req = 3'b111;
      k = 0;
      while ((done_log.size() < 4) && (k < 200)) begin
         step(1);
         k++;
         if (done_log.size() >= 4) bus.req = '0;
      end
      bus.req = '0;
      check("t2_done_count", chk_t'(done_log.size()), chk_t'(4));
      step(3);
      check("t2_gnt_latency", chk_t'(gnt_cyc[0] - c0), chk_t'(1));
      check("t2_gnt0", chk_t'(gnt_log[0]), chk_t'(3'b001));
      check("t2_gnt1", chk_t'(gnt_log[1]), chk_t'(3'b010));
      check("t2_gnt2", chk_t'(gnt_log[2]), chk_t'(3'b100));
      check("t2_gnt3", chk_t'(gnt_log[3]), chk_t'(3'b001));
      check("t2_grants", chk_t'(gnt_log.size()), chk_t'(4));
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t2_gap%0d", i), chk_t'(gnt_cyc[i+1] - done_cyc[i]), chk_t'(2));
      end
      check("t2_exp_empty", chk_t'(exp_q.size()), chk_t'(0));

      // zero-length burst
      clear_logs();
      bus.req_addr[2] = 32'h0000_5000;
      bus.req_len[2]  = 8'd0;
      drop_on_gnt = 1'b1;
      c0 = cyc;
      bus.req = 3'b100;
      run_until(1, 20, "t3");
      step(2);
      check("t3_gnt",         chk_t'(gnt_log[0]),              chk_t'(3'b100));
      check("t3_done",        chk_t'(done_log[0]),             chk_t'(3'b100));
      check("t3_gnt_latency", chk_t'(gnt_cyc[0] - c0),         chk_t'(1));
      check("t3_done_cycle",  chk_t'(done_cyc[0] - gnt_cyc[0]), chk_t'(0));
      check("t3_mem_req",     chk_t'(mem_req_cnt),             chk_t'(0));
      check("t3_rd_count",    chk_t'(rd_cnt),                  chk_t'(0));

      // backpressure and address wrap
      clear_logs();
      lat = 2;
      stall_cnt  = 5;
      stall_addr = 32'hFFFF_FFC0;
      bus.req_addr[0] = 32'hFFFF_FFC0;
      bus.req_len[0]  = 8'd2;
      expect_line(32'hFFFF_FFC0, 3'b001);
      expect_line(32'h0000_0000, 3'b001);
      bus.req = 3'b001;
      run_until(1, 80, "t4");
      step(2);
      check("t4_stall_hold", chk_t'(stall_hold),     chk_t'(5));
      check("t4_mem_req_cy", chk_t'(mem_req_cnt),    chk_t'(7));
      check("t4_addr0",      chk_t'(acc_log[0]),     chk_t'(32'hFFFF_FFC0));
      check("t4_addr1",      chk_t'(acc_log[1]),     chk_t'(32'h0000_0000));
      check("t4_done",       chk_t'(done_log[0]),    chk_t'(3'b001));
      check("t4_rd_count",   chk_t'(rd_cnt),         chk_t'(2));
      check("t4_exp_empty",  chk_t'(exp_q.size()),   chk_t'(0));

      // stray read data in IDLE
      clear_logs();
      step(2);
      bus.mem_rd_vld  = 1'b1;
      bus.mem_rd_data = {16{32'hDEAD_BEEF}};
      step(1);
      check("t5_err_set", chk_t'(bus.err), chk_t'(1));
      step(2);
      check("t5_no_rd_vld", chk_t'(rd_cnt),    chk_t'(0));
      check("t5_state",     chk_t'(dbg_state), chk_t'(ST_IDLE));
      lat = 1;
      bus.req_addr[1] = 32'h0000_2000;
      bus.req_len[1]  = 8'd1;
      expect_line(32'h0000_2000, 3'b010);
      bus.req = 3'b010;
      run_until(1, 40, "t5");
      step(1);
      check("t5_done",      chk_t'(done_log[0]),   chk_t'(3'b010));
      check("t5_err_held",  chk_t'(bus.err),       chk_t'(1));
      check("t5_rd_count",  chk_t'(rd_cnt),        chk_t'(1));
      check("t5_exp_empty", chk_t'(exp_q.size()),  chk_t'(0));

      // reset in the middle of a burst
      clear_logs();
      lat = 3;
      bus.req_addr[0] = 32'h0000_4000;
      bus.req_len[0]  = 8'd4;
      expect_line(32'h0000_4000, 3'b001);
      bus.req = 3'b001;
      k = 0;
      while ((dbg_state != ST_WAIT) && (k < 30)) begin
         step(1);
         k++;
      end
      check("t6_reached_wait", chk_t'(dbg_state), chk_t'(ST_WAIT));
      rst_n   = 1'b0;
      bus.req = '0;
      pend    = 0;
      exp_q.delete();
      exp_vld_q.delete();
      step(1);
      check("t6_gnt",      chk_t'(bus.gnt),      chk_t'(0));
      check("t6_rd_vld",   chk_t'(bus.rd_vld),   chk_t'(0));
      check("t6_done",     chk_t'(bus.done),     chk_t'(0));
      check("t6_mem_req",  chk_t'(bus.mem_req),  chk_t'(0));
      check("t6_err",      chk_t'(bus.err),      chk_t'(0));
      check("t6_mem_addr", chk_t'(bus.mem_addr), chk_t'(0));
      check("t6_rd_data",  bus.rd_data,          chk_t'(0));
      check("t6_state",    chk_t'(dbg_state),    chk_t'(ST_IDLE));
      rst_n = 1'b1;
      clear_logs();
      step(3);
      check("t6_no_done", chk_t'(done_log.size()), chk_t'(0));
      lat = 1;
      bus.req_addr[0] = 32'h0000_6000; bus.req_len[0] = 8'd1;
      bus.req_addr[1] = 32'h0000_7000; bus.req_len[1] = 8'd1;
      expect_line(32'h0000_6000, 3'b001);
      bus.req = 3'b011;
      run_until(1, 40, "t6");
      step(2);
      check("t6_ptr_reset_gnt", chk_t'(gnt_log[0]),     chk_t'(3'b001));
      check("t6_one_grant",     chk_t'(gnt_log.size()), chk_t'(1));
      check("t6_exp_empty",     chk_t'(exp_q.size()),   chk_t'(0));

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
